// File: rtl/reg_master.sv
// reg_master: bridges host register commands onto a byte-wide register bus.
// One command in flight, all outputs registered, read timeout, enforced bus idle gap.
module reg_master #(
  parameter int TIMEOUT = 15,
  parameter int GAP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] bus_data,
  output logic       bus_write,
  output logic       bus_read,
  input  logic [7:0] bus_rdata,
  input  logic       bus_valid
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_ADDR = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;
  localparam logic [2:0] S_GAP     = 3'd6;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

  logic [2:0] state;
  logic [7:0] wdata_q;
  logic [7:0] wait_cnt;
  logic [3:0] gap_cnt;

  // Outputs are computed for the state being entered, so each one is a flop.
  // Strobes, cmd_ready and rsp_valid default low every cycle; rsp_data/rsp_err hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wdata_q   <= 8'd0;
      wait_cnt  <= 8'd0;
      gap_cnt   <= 4'd0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'd0;
      rsp_err   <= 1'b0;
      bus_data  <= 8'd0;
      bus_write <= 1'b0;
      bus_read  <= 1'b0;
    end else begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      bus_data  <= 8'd0;
      bus_write <= 1'b0;
      bus_read  <= 1'b0;

      case (state)
        S_IDLE: begin
          // cmd_ready is still low in the first cycle after reset, so gate on it.
          if (cmd_valid && cmd_ready) begin
            wdata_q  <= cmd_wdata;
            bus_data <= cmd_addr;
            if (cmd_write) begin
              state     <= S_WR_ADDR;
              bus_write <= 1'b1;
            end else begin
              state    <= S_RD_REQ;
              bus_read <= 1'b1;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        S_WR_ADDR: begin
          state     <= S_WR_DATA;
          bus_write <= 1'b1;
          bus_data  <= wdata_q;
        end

        S_WR_DATA: begin
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= 8'd0;
        end

        S_RD_REQ: begin
          state    <= S_RD_WAIT;
          wait_cnt <= 8'd0;
        end

        S_RD_WAIT: begin
          // A valid on the last wait cycle still wins over the timeout.
          if (bus_valid) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= bus_rdata;
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= 8'd0;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        S_RESP: begin
          state   <= S_GAP;
          gap_cnt <= 4'd0;
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_master.sv
// tb_reg_master: randomized self-checking bench for reg_master against a
// cycle-level timing model and a 256-byte register-block model.
module tb_reg_master;

  localparam int TIMEOUT = 15;
  localparam int GAP     = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_data;
  logic [7:0] bus_data, bus_rdata;
  logic       bus_write, bus_read, bus_valid;

  int checks = 0;
  int passes = 0;

  logic [7:0] mem [256];

  // Trace of the most recent transaction, relative to its acceptance cycle C0.
  int         t_wait, t_rsp, t_ready, t_nrsp, t_both, t_idle, t_stray;
  logic [7:0] t_bd1, t_bd2, t_rd, t_hold_d;
  logic       t_bw1, t_bw2, t_br1, t_br2, t_re, t_hold_e;

  reg_master #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .bus_data  (bus_data),
    .bus_write (bus_write),
    .bus_read  (bus_read),
    .bus_rdata (bus_rdata),
    .bus_valid (bus_valid)
  );

  always #5 clk = ~clk;

  // Reference timing: the cycle (relative to C0) in which the response appears.
  function automatic int exp_rsp_cycle(input bit wr, input int valid_at);
    if (wr) return 3;
    if (valid_at >= 2 && valid_at <= 1 + TIMEOUT) return valid_at + 1;
    return 2 + TIMEOUT;
  endfunction

  function automatic bit exp_err(input bit wr, input int valid_at);
    return !wr && !(valid_at >= 2 && valid_at <= 1 + TIMEOUT);
  endfunction

  function automatic logic [7:0] exp_data(input bit wr, input int valid_at, input logic [7:0] rdata);
    if (wr || exp_err(wr, valid_at)) return 8'h00;
    return rdata;
  endfunction

  // Issues one command and records what the DUT does; outputs are sampled 1 ns after
  // each rising edge and inputs for that cycle are driven right after sampling.
  // valid_at/late_at are the cycles (from C0) in which bus_valid pulses, -1 for none.
  task automatic run_cmd(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                         input int valid_at, input int late_at, input logic [7:0] rdata,
                         input bit hold);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    bus_valid = 1'b0;
    t_wait = 0; t_rsp = -1; t_ready = -1; t_nrsp = 0; t_both = 0; t_idle = 0; t_stray = 0;
    t_rd = 8'h00; t_re = 1'b0; t_hold_d = 8'h00; t_hold_e = 1'b0;
    t_bd1 = 8'h00; t_bd2 = 8'h00; t_bw1 = 1'b0; t_bw2 = 1'b0; t_br1 = 1'b0; t_br2 = 1'b0;
    while (!cmd_ready && t_wait < 40) begin
      @(posedge clk); #1;
      t_wait++;
    end
    if (!cmd_ready) begin
      t_wait = -1;
      cmd_valid = 1'b0;
      return;
    end
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus_write && bus_read) t_both++;
      if (!bus_write && !bus_read && bus_data != 8'h00) t_idle++;
      if (k >= 3 && (bus_write || bus_read)) t_stray++;
      if (k == 1) begin t_bw1 = bus_write; t_br1 = bus_read; t_bd1 = bus_data; end
      if (k == 2) begin t_bw2 = bus_write; t_br2 = bus_read; t_bd2 = bus_data; end
      if (rsp_valid) begin
        t_nrsp++;
        if (t_rsp < 0) begin t_rsp = k; t_rd = rsp_data; t_re = rsp_err; end
      end
      if (cmd_ready) begin
        t_ready = k; t_hold_d = rsp_data; t_hold_e = rsp_err;
        bus_valid = 1'b0;
        cmd_valid = hold;
        break;
      end
      cmd_valid = hold;
      cmd_write = 1'($urandom);
      cmd_addr  = 8'($urandom);
      cmd_wdata = 8'($urandom);
      bus_valid = (k == valid_at) || (k == late_at);
      bus_rdata = (k == valid_at) ? rdata : 8'($urandom);
    end
    if (t_ready < 0) begin
      cmd_valid = 1'b0;
      bus_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h11; cmd_wdata = 8'h22;
    bus_valid = 1'b1; bus_rdata = 8'h33;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({cmd_ready, rsp_valid, rsp_data, rsp_err, bus_data, bus_write, bus_read} !== 20'h0)
        $display("[TB] FAIL reset_outputs: got %h expected %h",
                 {cmd_ready, rsp_valid, rsp_data, rsp_err, bus_data, bus_write, bus_read}, 20'h0);
      else passes++;
    end
    rst = 1'b0; cmd_valid = 1'b0; bus_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", cmd_ready);
    else passes++;
  endtask

  task automatic test_write();
    run_cmd(1'b1, 8'h03, 8'hED, -1, -1, 8'h00, 1'b0);
    mem[8'h03] = 8'hED;
    checks++;
    if ({t_bw1, t_br1, t_bd1, t_bw2, t_br2, t_bd2} !== {1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 8'hED})
      $display("[TB] FAIL write_bus: got %h expected %h",
               {t_bw1, t_br1, t_bd1, t_bw2, t_br2, t_bd2}, {1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 8'hED});
    else passes++;
    checks++;
    if ({t_rsp, t_re, t_rd} !== {32'd3, 1'b0, 8'h00})
      $display("[TB] FAIL write_rsp: got %h expected %h", {t_rsp, t_re, t_rd}, {32'd3, 1'b0, 8'h00});
    else passes++;
    checks++;
    if (t_ready !== 5) $display("[TB] FAIL write_ready: got cycle %0d expected cycle 5", t_ready);
    else passes++;
  endtask

  task automatic test_read();
    mem[8'h02] = 8'hEE;
    run_cmd(1'b0, 8'h02, 8'h5C, 4, -1, mem[8'h02], 1'b0);
    checks++;
    if ({t_bw1, t_br1, t_bd1, t_bw2, t_br2, t_bd2} !== {1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 8'h00})
      $display("[TB] FAIL read_bus: got %h expected %h",
               {t_bw1, t_br1, t_bd1, t_bw2, t_br2, t_bd2}, {1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 8'h00});
    else passes++;
    checks++;
    if ({t_rsp, t_re, t_rd} !== {32'd5, 1'b0, 8'hEE})
      $display("[TB] FAIL read_rsp: got %h expected %h", {t_rsp, t_re, t_rd}, {32'd5, 1'b0, 8'hEE});
    else passes++;
  endtask

  task automatic test_timeout();
    // No valid at all, plus a late pulse at C18 after the error response.
    run_cmd(1'b0, 8'h40, 8'h00, -1, TIMEOUT + 3, 8'hAA, 1'b0);
    checks++;
    if ({t_rsp, t_re, t_rd, t_nrsp} !== {32'(TIMEOUT + 2), 1'b1, 8'h00, 32'd1})
      $display("[TB] FAIL timeout_rsp: got %h expected %h",
               {t_rsp, t_re, t_rd, t_nrsp}, {32'(TIMEOUT + 2), 1'b1, 8'h00, 32'd1});
    else passes++;
    checks++;
    if ({t_hold_e, t_hold_d, t_ready} !== {1'b1, 8'h00, 32'(TIMEOUT + 3 + GAP)})
      $display("[TB] FAIL timeout_late: got %h expected %h",
               {t_hold_e, t_hold_d, t_ready}, {1'b1, 8'h00, 32'(TIMEOUT + 3 + GAP)});
    else passes++;
    // Valid on the very last wait cycle is still captured.
    run_cmd(1'b0, 8'h41, 8'h00, TIMEOUT + 1, -1, 8'h9B, 1'b0);
    checks++;
    if ({t_rsp, t_re, t_rd} !== {32'(TIMEOUT + 2), 1'b0, 8'h9B})
      $display("[TB] FAIL timeout_edge: got %h expected %h",
               {t_rsp, t_re, t_rd}, {32'(TIMEOUT + 2), 1'b0, 8'h9B});
    else passes++;
  endtask

  task automatic test_stray_valid();
    // Pulse during RD_REQ must be ignored; the capture comes from C5.
    run_cmd(1'b0, 8'h07, 8'h00, 5, 1, 8'h3C, 1'b0);
    checks++;
    if ({t_rsp, t_re, t_rd} !== {32'd6, 1'b0, 8'h3C})
      $display("[TB] FAIL stray_valid: got %h expected %h", {t_rsp, t_re, t_rd}, {32'd6, 1'b0, 8'h3C});
    else passes++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      bit         wr;
      logic [7:0] a, wd, rd, ed;
      int         va, la, er;
      bit         ee;
      wr = 1'($urandom);
      a  = 8'($urandom);
      wd = 8'($urandom);
      va = int'($urandom_range(2, TIMEOUT + 3));
      la = ($urandom_range(0, 1) == 1) ? 1 : -1;
      rd = mem[a];
      er = exp_rsp_cycle(wr, va);
      ee = exp_err(wr, va);
      ed = exp_data(wr, va, rd);
      run_cmd(wr, a, wd, va, la, rd, 1'b0);
      if (wr) mem[a] = wd;
      checks++;
      if ({t_bw1, t_br1, t_bd1, t_bw2, t_br2, t_bd2} !==
          {wr, !wr, a, wr, 1'b0, (wr ? wd : 8'h00)})
        $display("[TB] FAIL random_bus[%0d]: got %h expected %h", n,
                 {t_bw1, t_br1, t_bd1, t_bw2, t_br2, t_bd2}, {wr, !wr, a, wr, 1'b0, (wr ? wd : 8'h00)});
      else passes++;
      checks++;
      if ({t_rsp, t_re, t_rd} !== {32'(er), ee, ed})
        $display("[TB] FAIL random_rsp[%0d]: got %h expected %h", n, {t_rsp, t_re, t_rd}, {32'(er), ee, ed});
      else passes++;
      checks++;
      if ({t_wait, t_ready, t_nrsp, t_both, t_idle, t_stray, t_hold_d, t_hold_e} !==
          {32'd0, 32'(er + 1 + GAP), 32'd1, 32'd0, 32'd0, 32'd0, ed, ee})
        $display("[TB] FAIL random_proto[%0d]: got %h expected %h", n,
                 {t_wait, t_ready, t_nrsp, t_both, t_idle, t_stray, t_hold_d, t_hold_e},
                 {32'd0, 32'(er + 1 + GAP), 32'd1, 32'd0, 32'd0, 32'd0, ed, ee});
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         bad = 0;
    for (int n = 0; n < 20; n++) begin
      bit         wr;
      logic [7:0] a, wd;
      int         va;
      wr = (n % 2) == 0;
      a  = 8'($urandom);
      wd = 8'($urandom);
      va = int'($urandom_range(2, 6));
      exp_q.push_back(exp_data(wr, va, mem[a]));
      run_cmd(wr, a, wd, va, -1, mem[a], n < 19);
      if (wr) mem[a] = wd;
      got_q.push_back(t_rd);
      if (t_wait != 0 || t_nrsp != 1 || t_both != 0 || t_stray != 0 ||
          t_ready != exp_rsp_cycle(wr, va) + 1 + GAP) bad++;
    end
    checks++;
    if (bad !== 0) $display("[TB] FAIL b2b_protocol: got %0d bad transactions expected 0", bad);
    else passes++;
    for (int n = 0; n < 20; n++) begin
      checks++;
      if (got_q[n] !== exp_q[n]) $display("[TB] FAIL b2b_order[%0d]: got %h expected %h", n, got_q[n], exp_q[n]);
      else passes++;
    end
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 256; a++) begin
      int va;
      va = int'($urandom_range(2, 8));
      run_cmd(1'b0, 8'(a), 8'($urandom), va, -1, mem[a], 1'b0);
      checks++;
      if ({t_rsp, t_re, t_rd} !== {32'(va + 1), 1'b0, mem[a]})
        $display("[TB] FAIL sweep[%02h]: got %h expected %h", a, {t_rsp, t_re, t_rd}, {32'(va + 1), 1'b0, mem[a]});
      else passes++;
    end
  endtask

  task automatic test_reset_abort();
    int w = 0;
    int events = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h5A; bus_valid = 1'b0;
    while (!cmd_ready && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (cmd_ready !== 1'b1) $display("[TB] FAIL abort_accept: got ready %b expected 1", cmd_ready);
    else passes++;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; bus_valid = 1'b1; bus_rdata = 8'h77;
    @(posedge clk); #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_err, bus_data, bus_write, bus_read} !== 20'h0)
      $display("[TB] FAIL abort_outputs: got %h expected %h",
               {cmd_ready, rsp_valid, rsp_data, rsp_err, bus_data, bus_write, bus_read}, 20'h0);
    else passes++;
    rst = 1'b0; bus_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) $display("[TB] FAIL abort_ready: got %b expected 1", cmd_ready);
    else passes++;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid || bus_write || bus_read) events++;
      bus_valid = 1'($urandom);
      bus_rdata = 8'($urandom);
      @(posedge clk); #1;
    end
    bus_valid = 1'b0;
    checks++;
    if (events !== 0) $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", events);
    else passes++;
    run_cmd(1'b0, 8'h5A, 8'h00, TIMEOUT + 1, -1, 8'hC3, 1'b0);
    checks++;
    if ({t_rsp, t_re, t_rd} !== {32'(TIMEOUT + 2), 1'b0, 8'hC3})
      $display("[TB] FAIL abort_recover: got %h expected %h",
               {t_rsp, t_re, t_rd}, {32'(TIMEOUT + 2), 1'b0, 8'hC3});
    else passes++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    bus_valid = 1'b0; bus_rdata = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_stray_valid();
    test_random();
    test_back_to_back();
    test_sweep();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
